// File: rtl/vga_plot_if.sv
// Pixel-port bus between the drawing engines and the VGA plot arbiter.
// master = drawing side (requests and pixels), slave = arbiter (grants and adapter pixel).
interface vga_plot_if #(
  parameter int NUM_REQ = 3,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int C_W     = 3
);
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ-1:0]     done;
  logic [NUM_REQ*X_W-1:0] px;
  logic [NUM_REQ*Y_W-1:0] py;
  logic [NUM_REQ*C_W-1:0] pcolor;
  logic [NUM_REQ-1:0]     pplot;
  logic [NUM_REQ-1:0]     grant;
  logic [1:0]             owner;
  logic [X_W-1:0]         x;
  logic [Y_W-1:0]         y;
  logic [C_W-1:0]         color;
  logic                   plot;
  logic                   busy;
  logic                   timeout_err;

  modport master (
    output req, done, px, py, pcolor, pplot,
    input  grant, owner, x, y, color, plot, busy, timeout_err
  );

  modport slave (
    input  req, done, px, py, pcolor, pplot,
    output grant, owner, x, y, color, plot, busy, timeout_err
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the single VGA adapter pixel port between drawing engines.
// A grant is held for a whole burst until done, request drop or hold timeout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no owner; arbitrate from owner+1 when any req is high
// S_GRANT   | owner's pixel stream forwarded to the adapter, hold counted
// S_RELEASE | one dead cycle with grant low; arbitrate for the next owner
module vga_plot_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int MAX_HOLD = 20000
) (
  input logic      clock,
  input logic      reset,
  vga_plot_if.slave bus
);

  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   hold_cnt;
  logic [1:0]         owner_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [C_W-1:0]     color_q;
  logic               plot_q;
  logic               busy_q;
  logic               timeout_q;

  logic [X_W-1:0] sel_x;
  logic [Y_W-1:0] sel_y;
  logic [C_W-1:0] sel_color;
  logic           sel_plot;
  logic           sel_done;
  logic           sel_req;

  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    sel_plot  = 1'b0;
    sel_done  = 1'b0;
    sel_req   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == 2'(i)) begin
        sel_x     = bus.px[i*X_W +: X_W];
        sel_y     = bus.py[i*Y_W +: Y_W];
        sel_color = bus.pcolor[i*C_W +: C_W];
        sel_plot  = bus.pplot[i];
        sel_done  = bus.done[i];
        sel_req   = bus.req[i];
      end
    end
  end

  // Rotating search starting just after the last owner; first set bit wins.
  logic       found;
  logic [1:0] winner;
  logic [2:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = 3'(owner_q) + 3'(k);
      if (idx >= 3'(NUM_REQ)) idx = idx - 3'(NUM_REQ);
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && idx == 3'(j) && bus.req[j]) begin
          found  = 1'b1;
          winner = 2'(j);
        end
      end
    end
  end

  logic leave_grant;
  logic at_limit;

  assign at_limit    = (hold_cnt == CNT_LAST);
  assign leave_grant = sel_done || !sel_req || at_limit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      hold_cnt  <= '0;
      owner_q   <= 2'(NUM_REQ - 1);
      grant_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      color_q   <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        S_IDLE, S_RELEASE: begin
          plot_q <= 1'b0;
          if (found) begin
            state    <= S_GRANT;
            grant_q  <= ONE << winner;
            owner_q  <= winner;
            hold_cnt <= '0;
            busy_q   <= 1'b1;
          end else begin
            state   <= S_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        S_GRANT: begin
          // The pixel presented alongside done is still the burst's last pixel.
          x_q     <= sel_x;
          y_q     <= sel_y;
          color_q <= sel_color;
          plot_q  <= sel_plot;
          if (leave_grant) begin
            state     <= S_RELEASE;
            grant_q   <= '0;
            timeout_q <= at_limit && !sel_done && sel_req;
          end else if (!at_limit) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.owner       = owner_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.color       = color_q;
  assign bus.plot        = plot_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: directed vectors, a round-robin table and
// randomized traffic against a behavioural reference model.
module tb_vga_plot_arbiter;
  localparam int N    = 3;
  localparam int MAXH = 16;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  vga_plot_if #(.NUM_REQ(N), .X_W(8), .Y_W(7), .C_W(3)) bus ();

  vga_plot_arbiter #(
    .NUM_REQ(N), .X_W(8), .Y_W(7), .C_W(3), .MAX_HOLD(MAXH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req    = '0;
    bus.done   = '0;
    bus.pplot  = '0;
    bus.px     = '0;
    bus.py     = '0;
    bus.pcolor = '0;
  endtask

  // Reference model: one holder at a time, one dead cycle after every burst,
  // rotating search from the previous owner.
  int         m_holder;
  int         m_owner;
  int         m_hold;
  logic [2:0] e_grant;
  logic [7:0] e_x;
  logic [6:0] e_y;
  logic [2:0] e_c;
  logic       e_plot;
  logic       e_busy;
  logic       e_to;

  task automatic model_reset();
    m_holder = -1;
    m_owner  = N - 1;
    m_hold   = 0;
    e_grant  = '0;
    e_x      = '0;
    e_y      = '0;
    e_c      = '0;
    e_plot   = 1'b0;
    e_busy   = 1'b0;
    e_to     = 1'b0;
  endtask

  task automatic model_step();
    int h;
    int w;
    if (m_holder >= 0) begin
      h      = m_holder;
      e_x    = bus.px[h*8 +: 8];
      e_y    = bus.py[h*7 +: 7];
      e_c    = bus.pcolor[h*3 +: 3];
      e_plot = bus.pplot[h];
      e_to   = 1'b0;
      if (bus.done[h] || !bus.req[h] || m_hold == MAXH - 1) begin
        e_to     = (m_hold == MAXH - 1) && !bus.done[h] && bus.req[h];
        m_holder = -1;
        e_grant  = '0;
      end else begin
        m_hold++;
      end
    end else begin
      e_plot = 1'b0;
      e_to   = 1'b0;
      w      = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && bus.req[(m_owner + k) % N]) w = (m_owner + k) % N;
      if (w >= 0) begin
        m_holder = w;
        m_owner  = w;
        m_hold   = 0;
        e_grant  = 3'(1 << w);
        e_busy   = 1'b1;
      end else begin
        e_grant = '0;
        e_busy  = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] done;
    logic [2:0] grant;
    logic       busy;
  } vec_t;

  vec_t tab[$];

  initial begin
    vec_t v;
    int w;

    // Round-robin table: owners 0,1,2,0, each releasing via done 4 cycles after grant.
    for (int g = 0; g < 4; g++) begin
      w = g % N;
      for (int r = 0; r < 4; r++) begin
        v = '{req: 3'b111, done: 3'b000, grant: 3'(1 << w), busy: 1'b1};
        tab.push_back(v);
      end
      v = '{req: 3'b111, done: 3'(1 << w), grant: 3'b000, busy: 1'b1};
      tab.push_back(v);
    end
    v = '{req: 3'b000, done: 3'b000, grant: 3'b000, busy: 1'b0};
    tab.push_back(v);

    reset = 1'b1;
    clear_inputs();
    repeat (3) tick();
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_owner", 32'(bus.owner), 32'd2);
    chk("rst_pixel", {bus.x, bus.y, bus.color, bus.plot}, 32'h0);
    chk("rst_busy_to", {bus.busy, bus.timeout_err}, 32'h0);
    reset = 1'b0;

    // Single requester.
    repeat (4) tick();
    bus.req = 3'b010;
    tick();
    chk("single_grant", 32'(bus.grant), 32'b010);
    chk("single_owner", 32'(bus.owner), 32'd1);
    chk("single_busy", 32'(bus.busy), 32'd1);
    bus.px[8 +: 8]     = 8'd159;
    bus.py[7 +: 7]     = 7'd119;
    bus.pcolor[3 +: 3] = 3'b101;
    bus.pplot          = 3'b010;
    tick();
    chk("single_pixel", {bus.x, bus.y, bus.color, bus.plot}, {8'd159, 7'd119, 3'd5, 1'b1});
    bus.pplot = 3'b000;
    bus.done  = 3'b010;
    tick();
    chk("single_release", {bus.grant, bus.plot, bus.busy}, {3'b000, 1'b0, 1'b1});
    bus.done = 3'b000;
    bus.req  = 3'b000;
    tick();
    chk("single_idle", {bus.grant, bus.busy}, 32'h0);

    // Round-robin from a fresh reset.
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
    foreach (tab[i]) begin
      bus.req  = tab[i].req;
      bus.done = tab[i].done;
      tick();
      chk($sformatf("rr_row%0d", i), {bus.grant, bus.busy}, {tab[i].grant, tab[i].busy});
    end

    // Isolation of a non-owner's pplot and done.
    bus.req = 3'b001;
    tick();
    chk("iso_grant", {bus.grant, bus.owner}, {3'b001, 2'd0});
    bus.req              = 3'b101;
    bus.pplot            = 3'b100;
    bus.done             = 3'b100;
    bus.px[16 +: 8]      = 8'd200;
    tick();
    chk("iso_foreign", {bus.grant, bus.plot}, {3'b001, 1'b0});
    bus.pplot          = 3'b001;
    bus.done           = 3'b000;
    bus.px[0 +: 8]     = 8'd12;
    bus.py[0 +: 7]     = 7'd34;
    bus.pcolor[0 +: 3] = 3'd6;
    tick();
    chk("iso_own_pixel", {bus.grant, bus.x, bus.y, bus.color, bus.plot},
        {3'b001, 8'd12, 7'd34, 3'd6, 1'b1});

    // done together with the last pixel.
    bus.req            = 3'b001;
    bus.done           = 3'b001;
    bus.pplot          = 3'b001;
    bus.px[0 +: 8]     = 8'd77;
    bus.py[0 +: 7]     = 7'd55;
    bus.pcolor[0 +: 3] = 3'd3;
    tick();
    chk("last_pixel", {bus.grant, bus.busy, bus.x, bus.y, bus.color, bus.plot},
        {3'b000, 1'b1, 8'd77, 7'd55, 3'd3, 1'b1});
    bus.done  = 3'b000;
    bus.req   = 3'b000;
    bus.pplot = 3'b000;
    tick();
    chk("last_drain", {bus.grant, bus.busy, bus.plot}, 32'h0);
    bus.px[0 +: 8] = 8'd1;
    tick();
    chk("idle_hold_x", 32'(bus.x), 32'd77);

    // Forced release after MAXH grant cycles.
    bus.req = 3'b100;
    tick();
    chk("to_grant", {bus.grant, bus.owner}, {3'b100, 2'd2});
    for (int i = 1; i < MAXH; i++) begin
      tick();
      chk($sformatf("to_hold%0d", i), {bus.grant, bus.timeout_err}, {3'b100, 1'b0});
    end
    tick();
    chk("to_force", {bus.grant, bus.busy, bus.timeout_err}, {3'b000, 1'b1, 1'b1});
    tick();
    chk("to_regrant", {bus.grant, bus.timeout_err}, {3'b100, 1'b0});
    bus.req = 3'b000;
    tick();
    chk("to_drop", {bus.grant, bus.busy, bus.timeout_err}, {3'b000, 1'b1, 1'b0});
    tick();
    chk("to_idle", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of a burst.
    bus.req = 3'b010;
    tick();
    chk("mid_grant", 32'(bus.grant), 32'b010);
    bus.pplot = 3'b010;
    tick();
    chk("mid_plot", 32'(bus.plot), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_async", {bus.grant, bus.plot, bus.busy, bus.owner}, {3'b000, 1'b0, 1'b0, 2'd2});
    tick();
    reset     = 1'b0;
    bus.pplot = 3'b000;
    bus.req   = 3'b110;
    tick();
    chk("mid_restart", {bus.grant, bus.owner}, {3'b010, 2'd1});

    // Randomized traffic against the reference model.
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(15) == 0) bus.req[i] = ~bus.req[i];
      for (int i = 0; i < N; i++)
        bus.done[i] = ($urandom_range(11) == 0);
      bus.pplot  = 3'($urandom);
      bus.px     = 24'($urandom);
      bus.py     = 21'($urandom);
      bus.pcolor = 9'($urandom);
      model_step();
      tick();
      chk($sformatf("rand_c%0d", c),
          {bus.grant, bus.owner, bus.x, bus.y, bus.color, bus.plot, bus.busy, bus.timeout_err},
          {e_grant, 2'(m_owner), e_x, e_y, e_c, e_plot, e_busy, e_to});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
